// File: rtl/tile_stream_switch.sv
// tile_stream_switch: routes framed host bytes (valid/ready) to one of four
// tile switch ports, with a fixed settling gap between frames and a
// saturating count of rejected headers.
// Header byte: [7:6]=2'b10, [5:2]=LEN-1 (1..16 payload bytes), [1:0]=tile.
// Optional build macro BROADCAST_EN: header [7:6]=2'b11 writes every payload
// byte to all tile ports at once; without it such a header is rejected.
module tile_stream_switch #(
  parameter int         NUM_TILES  = 4,
  parameter int         GAP_CYCLES = 2,
  parameter logic [7:0] RESET_BYTE = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [8*NUM_TILES-1:0]   tile_data_out,
  output logic [NUM_TILES-1:0]     tile_strobe,
  output logic                     busy,
  output logic                     err_pulse,
  output logic [3:0]               err_count
);

`ifdef BROADCAST_EN
  localparam bit BCAST_OK = 1'b1;
`else
  localparam bit BCAST_OK = 1'b0;
`endif

  // Gap counter preload; the counter reaching zero marks the last gap cycle.
  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_GAP
  } state_t;

  state_t                   state_q;
  logic [3:0]               cnt_q;
  logic [1:0]               dest_q;
  logic                     bcast_q;
  logic                     in_ready_q;
  logic                     busy_q;
  logic                     err_pulse_q;
  logic [3:0]               err_count_q;
  logic [3:0]               err_count_d;
  logic [8*NUM_TILES-1:0]   tile_q;
  logic [NUM_TILES-1:0]     strobe_q;

  logic                     accept;
  logic                     hdr_unicast;
  logic                     hdr_bcast;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Handshake and header decode; in_ready is a register so there is no
  // combinational path from in_valid back to in_ready.
  always_comb begin
    accept      = in_valid & in_ready_q;
    hdr_unicast = (in_data[7:6] == 2'b10);
    hdr_bcast   = BCAST_OK & (in_data[7:6] == 2'b11);
    err_count_d = sat_inc4(err_count_q);
  end

  // Frame FSM with registered handshake, status and tile port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      dest_q      <= 2'd0;
      bcast_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= 4'd0;
      tile_q      <= {NUM_TILES{RESET_BYTE}};
      strobe_q    <= '0;
    end else begin
      strobe_q    <= '0;
      err_pulse_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (hdr_unicast || hdr_bcast) begin
              state_q <= S_PAYLOAD;
              cnt_q   <= in_data[5:2];
              dest_q  <= in_data[1:0];
              bcast_q <= hdr_bcast;
              busy_q  <= 1'b1;
            end else begin
              err_pulse_q <= 1'b1;
              err_count_q <= err_count_d;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            for (int i = 0; i < NUM_TILES; i++) begin
              if (bcast_q || (dest_q == 2'(i))) begin
                tile_q[8*i +: 8] <= in_data;
                strobe_q[i]      <= 1'b1;
              end
            end
            if (cnt_q == 4'd0) begin
              if (GAP_CYCLES == 0) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q    <= S_GAP;
                cnt_q      <= GAP_LOAD;
                in_ready_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        S_GAP: begin
          if (cnt_q == 4'd0) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          cnt_q      <= 4'd0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign err_pulse     = err_pulse_q;
  assign err_count     = err_count_q;
  assign tile_data_out = tile_q;
  assign tile_strobe   = strobe_q;

endmodule

// File: tb/tb_tile_stream_switch.sv
// Bench for tile_stream_switch: directed frames from the test plan followed by
// randomized traffic, all compared every cycle against a byte-level model.
module tb_tile_stream_switch;

  localparam int GAP = 2;
`ifdef BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] tile_data_out;
  logic [3:0]  tile_strobe;
  logic        busy;
  logic        err_pulse;
  logic [3:0]  err_count;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: frame bookkeeping by byte counts and edge timestamps.
  int          ne;        // index of the next clock edge
  int          gap_end;   // first edge index at which bytes are accepted again
  int          m_left;    // payload bytes still owed by the current frame
  logic [1:0]  m_dest;
  bit          m_bc;
  logic [7:0]  m_port[4];
  logic [3:0]  m_strobe;
  bit          m_errp;
  int          m_errc;

  tile_stream_switch #(.NUM_TILES(4), .GAP_CYCLES(GAP), .RESET_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tile_data_out(tile_data_out), .tile_strobe(tile_strobe),
    .busy(busy), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ne = 0; gap_end = 0; m_left = 0; m_dest = 2'd0; m_bc = 1'b0;
    for (int t = 0; t < 4; t++) m_port[t] = 8'h00;
    m_strobe = 4'd0; m_errp = 1'b0; m_errc = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d);
    bit rdy;
    rdy = (ne >= gap_end);
    m_strobe = 4'd0;
    m_errp = 1'b0;
    if (v && rdy) begin
      if (m_left == 0) begin
        if (d[7:6] == 2'b10 || (BCAST && d[7:6] == 2'b11)) begin
          m_left = int'(d[5:2]) + 1;
          m_dest = d[1:0];
          m_bc   = (d[7:6] == 2'b11);
        end else begin
          m_errp = 1'b1;
          if (m_errc < 15) m_errc++;
        end
      end else begin
        for (int t = 0; t < 4; t++)
          if (m_bc || t == int'(m_dest)) begin
            m_port[t]   = d;
            m_strobe[t] = 1'b1;
          end
        m_left--;
        if (m_left == 0) gap_end = ne + GAP + 1;
      end
    end
    ne++;
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, ne >= gap_end);
    chk("busy", busy, (m_left > 0) || (ne < gap_end));
    chk("ports", tile_data_out, {m_port[3], m_port[2], m_port[1], m_port[0]});
    chk("strobe", tile_strobe, m_strobe);
    chk("err_pulse", err_pulse, m_errp);
    chk("err_count", err_count, m_errc);
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    check_all();
  endtask

  // Hold one byte valid until the model says it was taken.
  task automatic send(input logic [7:0] d);
    bit done = 1'b0;
    int k = 0;
    while (!done && k < 64) begin
      done = (ne >= gap_end);
      cycle(1'b1, d);
      k++;
    end
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL send_timeout byte=%0h", d);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int lows, np, start, errc0;
    logic [7:0] d;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    chk("rst_ports", tile_data_out, 32'h0);
    chk("rst_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Frame to tile 2, two bytes back-to-back, then measure the gap.
    send(8'h86);
    send(8'h05);
    chk("t1_p2_first", tile_data_out[23:16], 8'h05);
    chk("t1_strobe1", tile_strobe, 4'b0100);
    send(8'hC3);
    chk("t1_p2_second", tile_data_out[23:16], 8'hC3);
    chk("t1_strobe2", tile_strobe, 4'b0100);
    chk("t1_others", {tile_data_out[31:24], tile_data_out[15:0]}, 24'h0);
    lows = 0;
    while (!in_ready && lows < 10) begin
      lows++;
      cycle(1'b0, 8'h00);
    end
    chk("t1_gap_len", lows, GAP);

    // Stalled payload: valid low for 5 cycles after the header.
    send(8'h81);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h51);
      chk("t2_busy_stall", busy, 1'b1);
      chk("t2_p1_hold", tile_data_out[15:8], 8'h00);
    end
    send(8'h51);
    chk("t2_p1", tile_data_out[15:8], 8'h51);
    repeat (GAP + 1) cycle(1'b0, 8'h00);

    // Seventeen bad headers: error pulses and saturation.
    np = 0;
    for (int i = 0; i < 17; i++) begin
      send(8'h00);
      if (err_pulse) np++;
    end
    chk("t3_pulses", np, 17);
    chk("t3_errc_sat", err_count, 4'd15);
    chk("t3_ports", tile_data_out, 32'h0000_5100 | 32'h00C3_0000);

    // Longest frame, then a header byte held off by the gap.
    send(8'hBC);
    for (int i = 0; i < 16; i++) send(8'hC0 + 8'(i));
    chk("t4_p0", tile_data_out[7:0], 8'hCF);
    start = ne;
    send(8'h85);
    chk("t4_holdoff", ne - start, GAP + 1);
    chk("t4_hdr_busy", busy, 1'b1);
    send(8'h11);
    send(8'h22);

    // Asynchronous reset in the middle of an 8-byte frame to tile 3.
    send(8'h9F);
    send(8'hA1); send(8'hA2); send(8'hA3);
    chk("t5_p3_pre", tile_data_out[31:24], 8'hA3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_ports", tile_data_out, 32'h0);
    chk("t5_async_busy", busy, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    #2 rst_n = 1'b1;
    send(8'h81);
    chk("t5_hdr_busy", busy, 1'b1);
    chk("t5_no_err", err_count, 4'd0);
    send(8'h51);
    chk("t5_p1", tile_data_out[15:8], 8'h51);
    repeat (GAP + 1) cycle(1'b0, 8'h00);

    // Broadcast header.
    errc0 = err_count;
    send(8'hC0);
    send(8'h07);
    if (BCAST) begin
      chk("t6_bc_ports", tile_data_out, 32'h0707_0707);
      chk("t6_bc_strobe", tile_strobe, 4'b1111);
    end else begin
      chk("t6_nobc_errc", err_count, errc0 + 2);
      chk("t6_nobc_ports", tile_data_out, 32'h0000_5100);
    end
    repeat (GAP + 1) cycle(1'b0, 8'h00);

    // Randomized traffic, mostly short legal frames.
    for (int i = 0; i < 1500; i++) begin
      if (m_left == 0 && ($urandom % 8) != 0)
        d = {2'b10, 2'b00, 2'($urandom), 2'($urandom)};
      else if (m_left == 0 && ($urandom % 2) == 0)
        d = {2'b11, 6'($urandom)};
      else
        d = 8'($urandom);
      cycle(($urandom % 4) != 0, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
